// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack transfer sequencer: op codes, FSM states
// and the SP register block's update-select codes.
package stack_seq_pkg;

    // Stack operation codes; 5..7 are illegal and ignored.
    localparam logic [2:0] OpPush  = 3'd0;
    localparam logic [2:0] OpPop   = 3'd1;
    localparam logic [2:0] OpPopAf = 3'd2;
    localparam logic [2:0] OpCall  = 3'd3;
    localparam logic [2:0] OpRet   = 3'd4;

    // SP register block select codes. The SP block owns these values; only
    // hold/increment/decrement are used by the sequencer.
    localparam logic [2:0] SpSelHold = 3'd0;
    localparam logic [2:0] SpSelInc  = 3'd1;
    localparam logic [2:0] SpSelDec  = 3'd2;
    localparam logic [2:0] SpSelTmp  = 3'd3;
    localparam logic [2:0] SpSelRel  = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StPuDec,
        StPuHi,
        StPuLo,
        StPoLo,
        StPoHi,
        StPoCap,
        StFin
    } state_e;

    // Ops that move a word onto the stack.
    function automatic logic op_is_push(input logic [2:0] op);
        return (op == OpPush) || (op == OpCall);
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OpRet;
    endfunction

endpackage

// File: rtl/stack_seq.sv
// Stack transfer sequencer: turns one PUSH/POP/CALL/RET-class request into
// two byte-wide memory cycles plus the matching SP steps.
module stack_seq
    import stack_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] word_in,
    input  logic [15:0] sp,
    input  logic [7:0]  mem_rdata,
    output logic [2:0]  sp_sel,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic        busy,
    output logic        done,
    output logic [15:0] word_out,
    output logic        pc_load
);

    state_e      state;
    logic [2:0]  op_lat;
    logic [15:0] word;

    logic        lo_en;
    logic        hi_en;
    logic [7:0]  lo_byte;

    // Byte-lane enables for word assembly; POP_AF clears the flag low nibble.
    always_comb begin
        lo_en   = (state == StPoHi);
        hi_en   = (state == StPoCap);
        lo_byte = (op_lat == OpPopAf) ? {mem_rdata[7:4], 4'h0} : mem_rdata;
    end

    // Sequencer FSM plus latched op and word register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= StIdle;
            op_lat <= OpPush;
            word   <= 16'h0000;
        end else begin
            case (state)
                StIdle: begin
                    if (start && op_is_legal(op)) begin
                        op_lat <= op;
                        if (op_is_push(op)) begin
                            word  <= word_in;
                            state <= StPuDec;
                        end else begin
                            state <= StPoLo;
                        end
                    end
                end
                StPuDec: state <= StPuHi;
                StPuHi:  state <= StPuLo;
                StPuLo:  state <= StFin;
                StPoLo:  state <= StPoHi;
                StPoHi:  state <= StPoCap;
                StPoCap: state <= StFin;
                StFin:   state <= StIdle;
                default: state <= StIdle;
            endcase
            if (lo_en) begin
                word[7:0] <= lo_byte;
            end
            if (hi_en) begin
                word[15:8] <= mem_rdata;
            end
        end
    end

    // Memory port and SP select decoded from state; addresses track live sp.
    always_comb begin
        sp_sel    = SpSelHold;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state)
            StPuDec: begin
                sp_sel = SpSelDec;
            end
            StPuHi: begin
                mem_addr  = sp;
                mem_wdata = word[15:8];
                mem_we    = 1'b1;
                sp_sel    = SpSelDec;
            end
            StPuLo: begin
                mem_addr  = sp;
                mem_wdata = word[7:0];
                mem_we    = 1'b1;
            end
            StPoLo, StPoHi: begin
                mem_addr = sp;
                mem_re   = 1'b1;
                sp_sel   = SpSelInc;
            end
            default: begin
            end
        endcase
    end

    // Status outputs; push ops report a zero word.
    always_comb begin
        busy     = (state != StIdle);
        done     = (state == StFin);
        pc_load  = (state == StFin) && (op_lat == OpRet);
        word_out = op_is_push(op_lat) ? 16'h0000 : word;
    end

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq with an SP register and byte memory
// environment and a transaction-level reference model.
module tb_stack_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [15:0] word_in;
    logic [15:0] sp;
    logic [7:0]  mem_rdata;
    logic [2:0]  sp_sel;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic        busy;
    logic        done;
    logic [15:0] word_out;
    logic        pc_load;

    stack_seq dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .word_in   (word_in),
        .sp        (sp),
        .mem_rdata (mem_rdata),
        .sp_sel    (sp_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .busy      (busy),
        .done      (done),
        .word_out  (word_out),
        .pc_load   (pc_load)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int n_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment: SP register block and 64 KiB byte memory.
    logic [7:0]  mem [65536];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = 16'h0;
    logic [7:0]  pre_data = 8'h0;
    logic        sp_load = 1'b0;
    logic [15:0] sp_val = 16'h0;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        sp = 16'h8000;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clock);
            if (pre_we) mem[pre_addr] <= pre_data;
            else if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr];
            if (sp_load) sp <= sp_val;
            else if (sp_sel == 3'd1) sp <= sp + 16'd1;
            else if (sp_sel == 3'd2) sp <= sp - 16'd1;
        end
    end

    // Reference model: phase 0 idle, 1..4 cycles since the accepted start.
    int          m_phase = 0;
    logic        m_push = 1'b0;
    logic [2:0]  m_op = 3'd0;
    logic [15:0] m_sp0 = 16'h0;
    logic [15:0] m_word = 16'h0;
    logic [15:0] last_out = 16'h0;
    logic        armed = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_phase = 0;
            last_out = 16'h0;
            armed = 1'b1;
        end else if (m_phase == 0) begin
            if (start && op <= 3'd4) begin
                m_phase = 1;
                m_op = op;
                m_sp0 = sp;
                m_push = (op == 3'd0) || (op == 3'd3);
                if (m_push) begin
                    m_word = word_in;
                end else begin
                    m_word = {mem[16'(sp + 16'd1)], mem[sp]};
                    if (op == 3'd2) m_word[3:0] = 4'h0;
                end
            end
        end else if (m_phase == 4) begin
            m_phase = 0;
            last_out = m_push ? 16'h0 : m_word;
        end else begin
            m_phase++;
        end
    end

    logic        e_busy, e_done, e_pc, e_we, e_re;
    logic [15:0] e_addr, e_wout, e_sp;
    logic [7:0]  e_wd;
    logic [2:0]  e_sel;

    // Compare every cycle on the falling edge.
    always @(negedge clock) begin
        if (armed) begin
            e_busy = (m_phase != 0);
            e_done = 1'b0; e_pc = 1'b0; e_we = 1'b0; e_re = 1'b0;
            e_addr = 16'h0; e_wd = 8'h0; e_sel = 3'd0; e_wout = last_out;
            e_sp = m_push ? 16'(m_sp0 - 16'd2) : 16'(m_sp0 + 16'd2);
            case (m_phase)
                1: if (m_push) e_sel = 3'd2;
                   else begin e_re = 1'b1; e_addr = m_sp0; e_sel = 3'd1; end
                2: if (m_push) begin
                       e_we = 1'b1; e_addr = m_sp0 - 16'd1; e_wd = m_word[15:8]; e_sel = 3'd2;
                   end else begin
                       e_re = 1'b1; e_addr = m_sp0 + 16'd1; e_sel = 3'd1;
                   end
                3: if (m_push) begin
                       e_we = 1'b1; e_addr = m_sp0 - 16'd2; e_wd = m_word[7:0];
                   end
                4: begin
                       e_done = 1'b1;
                       e_pc = (m_op == 3'd4);
                       e_wout = m_push ? 16'h0 : m_word;
                   end
                default: ;
            endcase
            if (done) n_done++;
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("pc_load", 32'(pc_load), 32'(e_pc));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_re", 32'(mem_re), 32'(e_re));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
            chk("sp_sel", 32'(sp_sel), 32'(e_sel));
            if (m_phase == 0 || m_phase == 4) chk("word_out", 32'(word_out), 32'(e_wout));
            if (m_phase == 4) chk("final_sp", 32'(sp), 32'(e_sp));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_sp(input logic [15:0] v);
        sp_load = 1'b1; sp_val = v;
        tick();
        sp_load = 1'b0;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    // One start pulse; returns word/pc_load at done and the cycle done was seen.
    task automatic run_op(input logic [2:0] o, input logic [15:0] w,
                          output logic [15:0] rw, output logic rp, output int rc);
        start = 1'b1; op = o; word_in = w;
        tick();
        start = 1'b0;
        rc = 0; rw = 16'h0; rp = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (done) begin
                rc = c; rw = word_out; rp = pc_load;
                break;
            end
            tick();
        end
        if (rc == 0) chk("done_timeout", 32'd0, 32'd1);
        tick();
    endtask

    logic [15:0] rw;
    logic        rp;
    int          rc;
    int          d0;

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; word_in = 16'h0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_word_out", 32'(word_out), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);

        // PUSH 0x1234 from SP 0xFFFE
        set_sp(16'hFFFE);
        run_op(3'd0, 16'h1234, rw, rp, rc);
        chk("push_done_cycle", 32'(rc), 32'd4);
        chk("push_hi_byte", 32'(mem[16'hFFFD]), 32'h12);
        chk("push_lo_byte", 32'(mem[16'hFFFC]), 32'h34);
        chk("push_sp", 32'(sp), 32'hFFFC);

        // POP it back
        run_op(3'd1, 16'h0, rw, rp, rc);
        chk("pop_word", 32'(rw), 32'h1234);
        chk("pop_pc_load", 32'(rp), 32'd0);
        chk("pop_sp", 32'(sp), 32'hFFFE);

        // POP_AF and RET with bytes EF/BE
        poke(16'hFFFC, 8'hEF);
        poke(16'hFFFD, 8'hBE);
        set_sp(16'hFFFC);
        run_op(3'd2, 16'h0, rw, rp, rc);
        chk("popaf_word", 32'(rw), 32'hBEE0);
        set_sp(16'hFFFC);
        run_op(3'd4, 16'h0, rw, rp, rc);
        chk("ret_word", 32'(rw), 32'hBEEF);
        chk("ret_pc_load", 32'(rp), 32'd1);

        // CALL across the SP wrap
        set_sp(16'h0001);
        run_op(3'd3, 16'hABCD, rw, rp, rc);
        chk("call_hi_byte", 32'(mem[16'h0000]), 32'hAB);
        chk("call_lo_byte", 32'(mem[16'hFFFF]), 32'hCD);
        chk("call_sp", 32'(sp), 32'hFFFF);

        // Reset in cycle 2 of a PUSH
        set_sp(16'hFFFE);
        poke(16'hFFFD, 8'h00);
        poke(16'hFFFC, 8'h00);
        d0 = n_done;
        start = 1'b1; op = 3'd0; word_in = 16'h5678;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_mid_hi_written", 32'(mem[16'hFFFD]), 32'h56);
        chk("rst_mid_lo_untouched", 32'(mem[16'hFFFC]), 32'h00);
        chk("rst_mid_no_done", 32'(n_done - d0), 32'd0);

        // start held through a POP, then illegal op 6
        set_sp(16'hFFFC);
        d0 = n_done;
        start = 1'b1; op = 3'd1;
        for (int i = 0; i < 5; i++) tick();
        start = 1'b0;
        chk("held_pop_word", 32'(word_out), 32'h5600);
        op = 3'd6; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("illegal_busy", 32'(busy), 32'd0);
        end
        start = 1'b0;
        tick();
        chk("held_one_op", 32'(n_done - d0), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 2) == 0);
            op = 3'($urandom_range(0, 7));
            word_in = 16'($urandom);
            if (m_phase == 0 && !start && !reset && $urandom_range(0, 9) == 0) begin
                sp_load = 1'b1;
                sp_val = 16'($urandom);
            end
            tick();
            sp_load = 1'b0;
        end
        reset = 1'b0; start = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stack_seq.md
# stack_seq

Stack transfer sequencer for the CPU core. It turns one PUSH/POP/CALL/RET-class request into the 8-bit memory cycles and stack-pointer steps that move a 16-bit word to or from the stack. It sits directly upstream of the SP register block: it drives that block's `sp_sel` select, reads back the live `sp`, and drives the CPU memory port while an operation is active.

## Interface
Parameters: none.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  3  operation code:
  - 0 PUSH
  - 1 POP
  - 2 POP_AF
  - 3 CALL
  - 4 RET
  - 5–7 illegal.
- `word_in`  in  16  word to push (register pair or return PC); latched at start.
- `sp`  in  16  current SP register value.
- `mem_rdata`  in  8  memory read data; valid the cycle after a `mem_re` cycle.
- `sp_sel`  out  3  SP register update select: 0 hold, 1 increment, 2 decrement.
- `mem_addr`  out  16  memory address.
- `mem_wdata`  out  8  memory write data.
- `mem_we`  out  1  write strobe; the write takes effect at the end of the cycle.
- `mem_re`  out  1  read strobe.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `word_out`  out  16  popped word; valid while `done` is high, held until the next accepted start.
- `pc_load`  out  1  high with `done` for RET only.

## Operation
- States: IDLE, PU_DEC, PU_HI, PU_LO, PO_LO, PO_HI, PO_CAP, FIN.
- Outside the states listed below, all strobes are 0, `sp_sel` = 0, `mem_addr` = 0 and `mem_wdata` = 0.
- IDLE:
  - `start` with op 0 or 3 latches `op` and `word_in`, then goes to PU_DEC.
  - `start` with op 1, 2 or 4 latches `op`, then goes to PO_LO.
  - Illegal op: `start` is ignored and the block stays in IDLE.
- PUSH/CALL sequence:
  - PU_DEC: `sp_sel` = 2.
  - PU_HI: `mem_addr` = `sp`, `mem_wdata` = word[15:8], `mem_we` = 1, `sp_sel` = 2.
  - PU_LO: `mem_addr` = `sp`, `mem_wdata` = word[7:0], `mem_we` = 1, `sp_sel` = 0.
  - Then FIN.
- POP/POP_AF/RET sequence:
  - PO_LO: `mem_addr` = `sp`, `mem_re` = 1, `sp_sel` = 1.
  - PO_HI: `mem_addr` = `sp`, `mem_re` = 1, `sp_sel` = 1; `mem_rdata` captured into word[7:0] at the end of the cycle.
  - PO_CAP: `mem_rdata` captured into word[15:8].
  - Then FIN.
- POP_AF: word[3:0] is forced to 0 at capture (flag register low nibble).
- FIN: `done` = 1, `word_out` = captured word (zero for push ops), `pc_load` = (op == RET). Next state IDLE.
- Address arithmetic is modulo 2^16. SP wrap (0x0000 - 1 → 0xFFFF, 0xFFFF + 1 → 0x0000) is performed by the SP block; the sequencer always addresses the live `sp`.
- `start` while `busy` is ignored; there is no queueing.

## Timing
- Reset values: state IDLE; all outputs 0; the latched op and word are 0.
- Reset asserted mid-operation: IDLE on the next edge. Strobes are 0 from the cycle after the reset edge. Any byte already written stays written. No `done` is produced.
- The start edge is cycle 0. Both sequence types are four cycles long: cycles 1–3 are the three sequence states above, and cycle 4 is FIN with `done` = 1.
- The earliest next `start` is sampled in cycle 5 (IDLE).
- Net SP change: −2 for PUSH/CALL, +2 for POP/POP_AF/RET.
- Read latency is exactly 1 cycle; the block has no wait-state input.
- Outputs are combinational from registered state plus `sp`; there is no combinational path from `start` to any output.

## Structure
- A shared CPU package (`stack_seq_pkg`) holds:
  - op codes;
  - the state enum;
  - `sp_sel` codes 0–2, shared with the SP register block (the SP block's codes are the source of truth; it also defines codes 3 and 4 for temp-buffer and relative load).
- Single module; no sub-module is warranted.
- Word assembly is a 16-bit register with byte-lane enables.

## Test plan
- PUSH, `sp` = 0xFFFE, `word_in` = 0x1234 → 0x12 written at 0xFFFD, 0x34 written at 0xFFFC, final `sp` = 0xFFFC, `done` in cycle 4.
- POP with mem[0xFFFC] = 0x34, mem[0xFFFD] = 0x12 → `word_out` = 0x1234, `sp` = 0xFFFE, `pc_load` = 0.
- POP_AF with bytes 0xEF/0xBE → `word_out` = 0xBEE0. RET with the same bytes → 0xBEEF and `pc_load` = 1.
- CALL with `sp` = 0x0001, `word_in` = 0xABCD → 0xAB written at 0x0000, 0xCD written at 0xFFFF, final `sp` = 0xFFFF.
- Reset asserted in cycle 2 of PUSH → only the high-byte write occurs, IDLE on the next cycle, `done` never pulses.
- `start` held high throughout a POP and `op` = 6 in IDLE → exactly one operation executes, and op 6 leaves `busy` = 0.
